// File: rtl/pool_pkg.sv
// Shared definitions for the max-pool frame sequencer.
//   POOL_KSIZE   : pool window size of the systolic array
//   POOL_COL_W   : width of all geometry counters and sizes
//   POOL_DATA_W  : pixel width
//   pool_state_e : sequencer FSM states
package pool_pkg;

    localparam int POOL_KSIZE  = 5;
    localparam int POOL_COL_W  = 10;
    localparam int POOL_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } pool_state_e;

endpackage

// File: rtl/pool_raster_counter.sv
// Raster position tracker for the padded frame.
// Holds row/column counters plus per-axis stride phase counters so the
// window-alignment test needs no divider.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : force all counters to zero (frame start)
//   adv_i          : advance one position (array pulse)
//   col_size_i/row_size_i : unpadded geometry
//   width_i/height_i      : padded geometry
//   stride_i       : pool stride 1..4
//   is_pad_o       : current position lies in the padding border
//   is_tag_o       : current position completes a stride-aligned window
//   is_last_o      : current position is the final one of the frame
module pool_raster_counter
    import pool_pkg::*;
#(
    parameter int PAD   = 2,
    parameter int KSIZE = POOL_KSIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  adv_i,
    input  logic [POOL_COL_W-1:0] col_size_i,
    input  logic [POOL_COL_W-1:0] row_size_i,
    input  logic [POOL_COL_W-1:0] width_i,
    input  logic [POOL_COL_W-1:0] height_i,
    input  logic [2:0]            stride_i,
    output logic                  is_pad_o,
    output logic                  is_tag_o,
    output logic                  is_last_o
);

    localparam logic [POOL_COL_W-1:0] PAD_L = POOL_COL_W'(PAD);
    localparam logic [POOL_COL_W-1:0] KM1   = POOL_COL_W'(KSIZE - 1);

    logic [POOL_COL_W-1:0] r_q, r_d, c_q, c_d;
    logic [2:0]            rph_q, rph_d, cph_q, cph_d;
    logic [2:0]            stride_m1;
    logic                  c_wrap;

    assign stride_m1 = stride_i - 3'd1;
    assign c_wrap    = (c_q == width_i - 10'd1);

    // Phase counters start at zero on the first window-completing index
    // (KSIZE-1) and wrap at stride, so phase==0 marks aligned positions.
    always_comb begin
        r_d   = r_q;
        c_d   = c_q;
        rph_d = rph_q;
        cph_d = cph_q;
        if (clear_i) begin
            r_d   = '0;
            c_d   = '0;
            rph_d = '0;
            cph_d = '0;
        end else if (adv_i) begin
            if (c_wrap) begin
                c_d   = '0;
                cph_d = '0;
                r_d   = r_q + 10'd1;
                if (r_q >= KM1) begin
                    rph_d = (rph_q == stride_m1) ? 3'd0 : rph_q + 3'd1;
                end else begin
                    rph_d = '0;
                end
            end else begin
                c_d = c_q + 10'd1;
                if (c_q >= KM1) begin
                    cph_d = (cph_q == stride_m1) ? 3'd0 : cph_q + 3'd1;
                end else begin
                    cph_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q   <= '0;
            c_q   <= '0;
            rph_q <= '0;
            cph_q <= '0;
        end else begin
            r_q   <= r_d;
            c_q   <= c_d;
            rph_q <= rph_d;
            cph_q <= cph_d;
        end
    end

    assign is_pad_o  = (r_q < PAD_L) || (r_q >= PAD_L + row_size_i) ||
                       (c_q < PAD_L) || (c_q >= PAD_L + col_size_i);
    assign is_tag_o  = (r_q >= KM1) && (c_q >= KM1) &&
                       (rph_q == 3'd0) && (cph_q == 3'd0);
    assign is_last_o = (r_q == height_i - 10'd1) && c_wrap;

endmodule

// File: rtl/pool_sequencer.sv
// Frame-level controller for the 5x5 max-pool systolic array.
// Rasters one channel through a zero-padded frame, injects padding pixels,
// drives the array pulse/ram_rst/col_size and forwards stride-aligned
// window results on a ready/valid stream.
//   DSP_clk, rst_n          : clock, asynchronous active-low reset
//   start, cfg_*            : frame start and geometry (latched in IDLE)
//   in_valid/in_data/in_ready : input pixel stream
//   pool_*                  : array control and feature path
//   out_valid/out_data/out_ready : pooled result stream
//   busy, done              : frame status
module pool_sequencer
    import pool_pkg::*;
#(
    parameter int                     PAD        = 2,
    parameter logic [POOL_DATA_W-1:0] PAD_VALUE  = 8'h00,
    parameter int                     KSIZE      = POOL_KSIZE,
    parameter int                     CLR_CYCLES = 4
) (
    input  logic                   DSP_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [POOL_COL_W-1:0]  cfg_col_size,
    input  logic [POOL_COL_W-1:0]  cfg_row_size,
    input  logic [2:0]             cfg_stride,
    input  logic                   in_valid,
    input  logic [POOL_DATA_W-1:0] in_data,
    output logic                   in_ready,
    output logic [POOL_DATA_W-1:0] pool_feature,
    output logic                   pool_pulse,
    output logic [POOL_COL_W-1:0]  pool_col_size,
    output logic                   pool_ram_rst,
    input  logic [POOL_DATA_W-1:0] pool_feature_out,
    output logic                   out_valid,
    output logic [POOL_DATA_W-1:0] out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int                    CLR_W = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0]      CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [POOL_COL_W-1:0] PAD2 = POOL_COL_W'(2 * PAD);

    pool_state_e            state_q, state_d;
    logic [POOL_COL_W-1:0]  col_q, col_d, row_q, row_d;
    logic [POOL_COL_W-1:0]  width_q, width_d, height_q, height_d;
    logic [2:0]             stride_q, stride_d;
    logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                   pend_q, pend_d;
    logic                   out_valid_q, out_valid_d;
    logic [POOL_DATA_W-1:0] out_data_q, out_data_d;

    logic is_pad, is_tag, is_last;
    logic scan, stall, allow;

    pool_raster_counter #(
        .PAD   (PAD),
        .KSIZE (KSIZE)
    ) u_raster (
        .clk_i      (DSP_clk),
        .rst_ni     (rst_n),
        .clear_i    (state_q == ST_CLEAR),
        .adv_i      (pool_pulse),
        .col_size_i (col_q),
        .row_size_i (row_q),
        .width_i    (width_q),
        .height_i   (height_q),
        .stride_i   (stride_q),
        .is_pad_o   (is_pad),
        .is_tag_o   (is_tag),
        .is_last_o  (is_last)
    );

    // Handshake semantics (both streams): a transfer happens on a rising
    // clock edge where valid and ready are both high; valid never drops and
    // data never changes until that transfer. A new array pulse is issued
    // only when the result register cannot be overwritten, so no pooled
    // result is ever lost under backpressure.
    assign stall = out_valid_q & ~out_ready;
    assign allow = ~pend_q & ~stall;
    assign scan  = (state_q == ST_SCAN);

    // FSM state register
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_cnt_q == CLR_LAST) state_d = ST_SCAN;
            ST_SCAN:  if (pool_pulse && is_last) state_d = ST_FLUSH;
            ST_FLUSH: if (!pend_q && !stall) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready     = scan & ~is_pad & allow;
        pool_pulse   = scan & allow & (is_pad | in_valid);
        pool_feature = '0;
        if (scan) begin
            pool_feature = is_pad ? PAD_VALUE : in_data;
        end
        pool_ram_rst = (state_q == ST_CLEAR);
        busy         = (state_q == ST_CLEAR) || scan || (state_q == ST_FLUSH);
        done         = (state_q == ST_DONE);
    end

    // Datapath next-state: config latch, clear counter, result register.
    // The array presents the window result the cycle after the tagged
    // pulse, hence the one-cycle pend stage.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        width_d     = width_q;
        height_d    = height_q;
        stride_d    = stride_q;
        clr_cnt_d   = '0;
        pend_d      = pool_pulse & is_tag;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (state_q == ST_IDLE && start) begin
            col_d    = cfg_col_size;
            row_d    = cfg_row_size;
            width_d  = cfg_col_size + PAD2;
            height_d = cfg_row_size + PAD2;
            stride_d = cfg_stride;
        end
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
        if (pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = pool_feature_out;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            stride_q    <= '0;
            clr_cnt_q   <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            width_q     <= width_d;
            height_q    <= height_d;
            stride_q    <= stride_d;
            clr_cnt_q   <= clr_cnt_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign pool_col_size = width_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;

endmodule

// File: tb/tb_pool_sequencer.sv
// Bench for pool_sequencer: a behavioural model of the pool array supplies
// pool_feature_out; expected pooled values come from a direct max-pool of
// the padded input frame.
`timescale 1ns/1ps
module tb_pool_sequencer;

    localparam int         PAD  = 2;
    localparam logic [7:0] PADV = 8'h00;
    localparam int         K    = 5;
    localparam int         CLR  = 4;

    logic       DSP_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cfg_col_size = '0;
    logic [9:0] cfg_row_size = '0;
    logic [2:0] cfg_stride = 3'd1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [7:0] pool_feature;
    logic       pool_pulse;
    logic [9:0] pool_col_size;
    logic       pool_ram_rst;
    logic [7:0] pool_feature_out;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       done;

    pool_sequencer #(
        .PAD        (PAD),
        .PAD_VALUE  (PADV),
        .KSIZE      (K),
        .CLR_CYCLES (CLR)
    ) dut (
        .DSP_clk          (DSP_clk),
        .rst_n            (rst_n),
        .start            (start),
        .cfg_col_size     (cfg_col_size),
        .cfg_row_size     (cfg_row_size),
        .cfg_stride       (cfg_stride),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .pool_feature     (pool_feature),
        .pool_pulse       (pool_pulse),
        .pool_col_size    (pool_col_size),
        .pool_ram_rst     (pool_ram_rst),
        .pool_feature_out (pool_feature_out),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .busy             (busy),
        .done             (done)
    );

    // ---------------- clock ----------------
    always #5 DSP_clk = ~DSP_clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] pix_q[$];
    int         pulse_cnt  = 0;
    int         rst_cycles = 0;
    int         done_cnt   = 0;
    bit         first_pulse_seen = 0;
    int         ready_mode = 0;
    int         hold_left  = 0;
    bit         hold_started = 0;
    bit         stall_prev = 0;
    logic [7:0] stall_data = '0;

    // ---------------- pool array model ----------------
    // Pulses are stored in raster order; each pulse outputs the max of the
    // 5x5 window whose bottom-right corner is the new pixel.
    logic [7:0] arr_mem [0:4095];
    int         arr_cnt = 0;

    function automatic logic [7:0] win_max(input int k, input logic [7:0] nv, input int w);
        int r, c, idx;
        logic [7:0] m, v;
        m = '0;
        if (w > 0) begin
            r = k / w;
            c = k % w;
            if (r >= K - 1 && c >= K - 1) begin
                for (int rr = r - (K - 1); rr <= r; rr++) begin
                    for (int cc = c - (K - 1); cc <= c; cc++) begin
                        idx = rr * w + cc;
                        v = (idx == k) ? nv : arr_mem[idx[11:0]];
                        if (v > m) m = v;
                    end
                end
            end
        end
        return m;
    endfunction

    always @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_cnt          <= 0;
            pool_feature_out <= '0;
        end else if (pool_ram_rst) begin
            arr_cnt          <= 0;
            pool_feature_out <= '0;
        end else if (pool_pulse) begin
            arr_mem[arr_cnt[11:0]] <= pool_feature;
            pool_feature_out       <= win_max(arr_cnt, pool_feature, int'(pool_col_size));
            arr_cnt                <= arr_cnt + 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge DSP_clk);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!hold_started && out_valid) begin
                        hold_started = 1;
                        hold_left    = 10;
                    end
                    out_ready = (hold_left == 0);
                    if (hold_left > 0) hold_left--;
                end
            endcase
            #1;
            if (rst_n) begin
                if (pool_ram_rst) begin
                    if (!first_pulse_seen) rst_cycles++;
                    check("no_pulse_in_clear", int'(pool_pulse), 0);
                end
                if (pool_pulse) begin
                    pulse_cnt++;
                    first_pulse_seen = 1;
                end
                if (done) done_cnt++;
                if (out_valid && !out_ready) begin
                    check("stall_no_pulse", int'(pool_pulse), 0);
                    check("stall_no_in_ready", int'(in_ready), 0);
                    if (stall_prev) check("stall_data_stable", int'(out_data), int'(stall_data));
                    stall_prev = 1;
                    stall_data = out_data;
                end else begin
                    stall_prev = 0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0d expected none", out_data);
                    end else begin
                        check("out_data", int'(out_data), int'(exp_q.pop_front()));
                    end
                    got_q.push_back(out_data);
                end
            end else begin
                stall_prev = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string p);
        check({p, "_in_ready"}, int'(in_ready), 0);
        check({p, "_pool_pulse"}, int'(pool_pulse), 0);
        check({p, "_pool_ram_rst"}, int'(pool_ram_rst), 0);
        check({p, "_pool_feature"}, int'(pool_feature), 0);
        check({p, "_pool_col_size"}, int'(pool_col_size), 0);
        check({p, "_out_valid"}, int'(out_valid), 0);
        check({p, "_out_data"}, int'(out_data), 0);
        check({p, "_busy"}, int'(busy), 0);
        check({p, "_done"}, int'(done), 0);
    endtask

    // vmode: 0 always valid, 1 alternating, 2 random
    // rmode: 0 always ready, 1 random, 2 hold 10 cycles after first valid
    // pixmode: 0 raster 1..N, 1 random
    task automatic run_frame(input int col, input int row, input int stride,
                             input int vmode, input int rmode, input int pixmode,
                             input int abort_at, input int restart_at);
        int w, h, cyc, n_exp, pr, pc;
        bit fin;
        logic [7:0] pix[$];
        logic [7:0] m, v;
        w = col + 2 * PAD;
        h = row + 2 * PAD;
        pix.delete();
        for (int i = 0; i < col * row; i++) begin
            pix.push_back((pixmode == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255)));
        end
        // reference max-pool over the padded frame
        exp_q.delete();
        for (int oi = 0; oi * stride <= h - K; oi++) begin
            for (int oj = 0; oj * stride <= w - K; oj++) begin
                m = '0;
                for (int dr = 0; dr < K; dr++) begin
                    for (int dc = 0; dc < K; dc++) begin
                        pr = oi * stride + dr;
                        pc = oj * stride + dc;
                        if (pr < PAD || pr >= PAD + row || pc < PAD || pc >= PAD + col)
                            v = PADV;
                        else
                            v = pix[(pr - PAD) * col + (pc - PAD)];
                        if (v > m) m = v;
                    end
                end
                exp_q.push_back(m);
            end
        end
        n_exp = exp_q.size();
        pix_q = pix;
        pulse_cnt = 0; rst_cycles = 0; done_cnt = 0; first_pulse_seen = 0;
        got_q.delete(); hold_started = 0; hold_left = 0; ready_mode = rmode;

        @(negedge DSP_clk);
        cfg_col_size = 10'(col);
        cfg_row_size = 10'(row);
        cfg_stride   = 3'(stride);
        start        = 1'b1;
        @(negedge DSP_clk);
        start = 1'b0;
        #1;
        check("busy_after_start", int'(busy), 1);
        check("pool_col_size", int'(pool_col_size), w);
        check("ram_rst_after_start", int'(pool_ram_rst), 1);
        #1;
        cyc = 0;
        fin = 0;
        while (!fin && cyc < 20000) begin
            if (pix_q.size() == 0) in_valid = 1'b0;
            else if (vmode == 0) in_valid = 1'b1;
            else if (vmode == 1) in_valid = (cyc % 2 == 0);
            else in_valid = 1'($urandom_range(0, 1));
            in_data = (pix_q.size() != 0) ? pix_q[0] : 8'h00;
            if (restart_at != 0 && cyc == restart_at) begin
                start = 1'b1;
                cfg_col_size = 10'd7;
                cfg_row_size = 10'd3;
                cfg_stride   = 3'd3;
            end else begin
                start = 1'b0;
                cfg_col_size = 10'(col);
                cfg_row_size = 10'(row);
                cfg_stride   = 3'(stride);
            end
            if (abort_at != 0 && cyc == abort_at) begin
                check("abort_in_scan_busy", int'(busy), 1);
                rst_n = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_outputs("midrst");
                repeat (2) @(negedge DSP_clk);
                rst_n = 1'b1;
                exp_q.delete();
                pix_q.delete();
                return;
            end
            #1;
            if (in_valid && in_ready) void'(pix_q.pop_front());
            if (done) fin = 1;
            @(negedge DSP_clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got no done after %0d cycles, required done", cyc);
        end
        repeat (3) @(negedge DSP_clk);
        #1;
        check("pulse_count", pulse_cnt, w * h);
        check("ram_rst_cycles", rst_cycles, CLR);
        check("done_count", done_cnt, 1);
        check("output_count", got_q.size(), n_exp);
        check("exp_q_empty", exp_q.size(), 0);
        check("pixels_consumed", pix_q.size(), 0);
        check("idle_busy", int'(busy), 0);
        check("col_size_kept", int'(pool_col_size), w);
    endtask

    task automatic check_basic_corners(input string p);
        if (got_q.size() >= 16) begin
            check({p, "_out00"}, int'(got_q[0]), 11);
            check({p, "_out33"}, int'(got_q[15]), 16);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_corners: got %0d outputs required 16", p, got_q.size());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge DSP_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge DSP_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge DSP_clk);

        run_frame(4, 4, 1, 0, 0, 0, 0, 0);
        check_basic_corners("basic");

        run_frame(6, 6, 2, 0, 0, 1, 0, 0);

        run_frame(4, 4, 1, 1, 0, 0, 0, 0);
        check_basic_corners("in_stall");

        run_frame(4, 4, 1, 0, 2, 0, 0, 0);
        check_basic_corners("backpressure");

        run_frame(4, 4, 1, 0, 0, 0, 30, 0);
        repeat (2) @(negedge DSP_clk);
        run_frame(4, 4, 1, 0, 0, 0, 0, 0);
        check_basic_corners("restart");

        run_frame(4, 4, 1, 0, 0, 0, 0, 20);
        check_basic_corners("start_busy");

        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 4),
                      2, 1, 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
